// File: rtl/primal_pkg.sv
// rtl/primal_pkg.sv - shared op/state encodings and GCD guard constant for primal_arith_core
package primal_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_MUL     = 2'b01,
        OP_GCD     = 2'b10,
        OP_COPRIME = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_MUL  = 3'd2,
        ST_GCD  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Binary GCD gives up after this many steps per operand bit.
    localparam int unsigned GCD_GUARD_MULT = 4;

endpackage

// File: rtl/primal_arith_core_if.sv
// rtl/primal_arith_core_if.sv - request/response handshake bundle for primal_arith_core
interface primal_arith_core_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] prime_a;
    logic [WIDTH-1:0] prime_b;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             constitutional_violation;

    modport master (
        output in_valid, op, prime_a, prime_b, abort, out_ready,
        input  in_ready, out_valid, result, result_hi, constitutional_violation
    );

    modport slave (
        input  in_valid, op, prime_a, prime_b, abort, out_ready,
        output in_ready, out_valid, result, result_hi, constitutional_violation
    );
endinterface

// File: rtl/primal_stein_gcd.sv
// rtl/primal_stein_gcd.sv - iterative binary (Stein) GCD, one step per cycle with step guard
module primal_stein_gcd
    import primal_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] count_o,
    output logic             violation_o
);
    localparam int unsigned     GUARD   = GCD_GUARD_MULT * WIDTH;
    localparam int              CW      = $clog2(GUARD + 1);
    localparam int              KW      = $clog2(WIDTH + 1);
    localparam longint unsigned CNT_MAX = (64'd1 << WIDTH) - 64'd1;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_o      = 1'b0;
        result_o    = '0;
        violation_o = 1'b0;
        if (clear_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            k_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Zero operands can only be present on the first cycle: no step ever produces zero.
            if (a_q == '0 && b_q == '0) begin
                done_o      = 1'b1;
                violation_o = 1'b1;
                busy_d      = 1'b0;
            end else if (a_q == '0) begin
                done_o   = 1'b1;
                result_o = b_q;
                busy_d   = 1'b0;
            end else if (b_q == '0) begin
                done_o   = 1'b1;
                result_o = a_q;
                busy_d   = 1'b0;
            end else if (a_q == b_q) begin
                done_o   = 1'b1;
                result_o = a_q << k_q;
                busy_d   = 1'b0;
            end else if (32'(cnt_q) == GUARD) begin
                done_o      = 1'b1;
                violation_o = 1'b1;
                busy_d      = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = (64'(cnt_q) > CNT_MAX) ? {WIDTH{1'b1}} : WIDTH'(cnt_q);

endmodule

// File: rtl/primal_arith_core.sv
// rtl/primal_arith_core.sv - handshake arithmetic core: ADD, shift-add MUL, GCD and COPRIME
module primal_arith_core
    import primal_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    primal_arith_core_if.slave bus
);
    localparam int CNTW = $clog2(WIDTH);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH:0]   prod_q, prod_d;
    logic [CNTW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               viol_q, viol_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_hi_sum;
    logic [2*WIDTH:0]   prod_next;
    logic               mul_last;

    logic               gcd_start, gcd_clear, gcd_busy, gcd_done, gcd_viol, gcd_is_one;
    logic [WIDTH-1:0]   gcd_result, gcd_count;

    assign add_sum    = {1'b0, a_q} + {1'b0, b_q};
    // Upper half carries one spare bit so the partial sum never overflows before the shift.
    assign mul_hi_sum = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, a_q} : '0);
    assign prod_next  = {mul_hi_sum, prod_q[WIDTH-1:0]} >> 1;
    assign mul_last   = (bit_cnt_q == CNTW'(WIDTH - 1));

    assign gcd_start  = (state_q == ST_IDLE) && bus.in_valid && bus.op[1];
    assign gcd_clear  = (state_q == ST_GCD) && bus.abort;
    assign gcd_is_one = (gcd_result == WIDTH'(1)) && !gcd_viol;

    primal_stein_gcd #(.WIDTH(WIDTH)) u_gcd (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (gcd_start),
        .clear_i    (gcd_clear),
        .a_i        (bus.prime_a),
        .b_i        (bus.prime_b),
        .busy_o     (gcd_busy),
        .done_o     (gcd_done),
        .result_o   (gcd_result),
        .count_o    (gcd_count),
        .violation_o(gcd_viol)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    case (op_e'(bus.op))
                        OP_ADD:  state_d = ST_ADD;
                        OP_MUL:  state_d = MUL_EN ? ST_MUL : ST_ADD;
                        default: state_d = ST_GCD;
                    endcase
                end
            end
            ST_ADD:  state_d = bus.abort ? ST_IDLE : ST_DONE;
            ST_MUL: begin
                if (bus.abort)     state_d = ST_IDLE;
                else if (mul_last) state_d = ST_DONE;
            end
            ST_GCD: begin
                if (bus.abort)                 state_d = ST_IDLE;
                else if (gcd_busy && gcd_done) state_d = ST_DONE;
            end
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        bit_cnt_d   = bit_cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        viol_d      = viol_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_d      = op_e'(bus.op);
                    a_d       = bus.prime_a;
                    b_d       = bus.prime_b;
                    prod_d    = {{(WIDTH + 1){1'b0}}, bus.prime_b};
                    bit_cnt_d = '0;
                end
            end
            ST_ADD: begin
                if (!bus.abort) begin
                    result_d    = add_sum[WIDTH-1:0];
                    result_hi_d = {{(WIDTH - 1){1'b0}}, add_sum[WIDTH]};
                    // Only reachable with op MUL when the multiplier is not built.
                    viol_d      = (op_q == OP_MUL);
                end
            end
            ST_MUL: begin
                if (!bus.abort) begin
                    prod_d    = prod_next;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (mul_last) begin
                        result_d    = prod_next[WIDTH-1:0];
                        result_hi_d = prod_next[2*WIDTH-1:WIDTH];
                        viol_d      = 1'b0;
                    end
                end
            end
            ST_GCD: begin
                if (!bus.abort && gcd_busy && gcd_done) begin
                    result_d    = (op_q == OP_COPRIME) ? {{(WIDTH - 1){1'b0}}, gcd_is_one}
                                                       : gcd_result;
                    result_hi_d = gcd_count;
                    viol_d      = gcd_viol;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            bit_cnt_q   <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            viol_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            bit_cnt_q   <= bit_cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            viol_q      <= viol_d;
        end
    end

    assign bus.in_ready                 = (state_q == ST_IDLE);
    assign bus.out_valid                = (state_q == ST_DONE);
    assign bus.result                   = result_q;
    assign bus.result_hi                = result_hi_q;
    assign bus.constitutional_violation = viol_q;

endmodule

// File: doc/primal_arith_core.md
PRIMAL_ARITH_CORE -- requirements
Module: primal_arith_core

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand width (legal range 4..32).
REQ-002 Parameter MUL_EN, default 1, SHALL build the MUL datapath when 1; when 0, MUL SHALL complete as ADD with violation set.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  core accepts; SHALL be high only in IDLE.
REQ-007 op  input  2  00=ADD, 01=MUL, 10=GCD, 11=COPRIME.
REQ-008 prime_a, prime_b  input  WIDTH each  operands.
REQ-009 abort  input  1  synchronous cancel of the operation in flight.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  low result word.
REQ-013 result_hi  output  WIDTH  ADD carry in bit 0; MUL high word; GCD/COPRIME iteration count (saturating).
REQ-014 constitutional_violation  output  1  operation ill-defined or guard tripped; qualified by out_valid.

Function
REQ-015 FSM states SHALL be IDLE, ADD, MUL, GCD, DONE.
REQ-016 Accept SHALL occur on an edge with in_valid & in_ready; operands and op SHALL be registered then.
REQ-017 ADD SHALL compute the full WIDTH+1 sum in one cycle in state ADD; out_valid SHALL rise on the second edge after accept.
REQ-018 MUL SHALL use shift-add, one multiplier bit per cycle for exactly WIDTH cycles, giving a 2*WIDTH product; out_valid SHALL rise on edge WIDTH+1 after accept.
REQ-019 GCD SHALL use binary (Stein) iteration, one step per cycle: both even -> halve both, k++; a even -> halve a; b even -> halve b; else subtract smaller from larger; terminate when a==b, result = a<<k.
REQ-020 If exactly one GCD operand is zero, result SHALL be the other operand after one cycle, violation 0.
REQ-021 If both operands are zero, result SHALL be 0 and violation 1, with a one-cycle latency.
REQ-022 The GCD iteration counter SHALL abort at 4*WIDTH steps with result 0 and violation 1.
REQ-023 COPRIME SHALL run GCD; result SHALL be 1 if the gcd equals 1, else 0; result_hi SHALL hold the iteration count.
REQ-024 In DONE, out_valid SHALL be 1 and all outputs SHALL be held stable until out_ready=1; the FSM SHALL then return to IDLE, and in_ready SHALL rise on the next cycle.
REQ-025 abort=1 in ADD, MUL or GCD SHALL return the FSM to IDLE on the next edge with no out_valid; abort SHALL be ignored in IDLE and DONE.
REQ-026 in_valid while busy SHALL be ignored; no queuing.

Reset
REQ-027 rst_n low SHALL force IDLE, in_ready=1 after release, and out_valid=0, result=0, result_hi=0, constitutional_violation=0, and all datapath registers to 0, regardless of the state in flight.
REQ-028 Reset mid-operation SHALL discard the operation; no out_valid SHALL follow reset release.

Structure
REQ-029 Package primal_pkg SHALL hold the op encoding enum, the FSM state enum and the GCD guard-multiplier constant (4).
REQ-030 The binary-GCD step datapath SHALL be the sub-module primal_stein_gcd (WIDTH parameter, start/busy/done, result, count, violation); the core SHALL contain the FSM, ADD and MUL.

Verification (WIDTH=16)
REQ-031 ADD 0xFFFF+0x0001 -> result 0x0000, result_hi 0x0001, out_valid on the 2nd edge after accept.
REQ-032 MUL 0xFFFF*0xFFFF -> result 0x0001, result_hi 0xFFFE, out_valid on edge 17; MUL 0x00FF*0x0101 -> result 0xFFFF, result_hi 0.
REQ-033 GCD 48,18 -> result 6; COPRIME 35,64 -> result 1; COPRIME 0,0 -> result 0, violation 1; GCD 0,7 -> result 7, violation 0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; accept on the 6th cycle -> in_ready=1 on the next cycle.
REQ-035 Assert abort on cycle 5 of a MUL -> IDLE next edge, no out_valid; pulse rst_n mid-GCD -> all outputs 0, and a fresh ADD 3+4 -> result 7.
